// File: rtl/phy_rx_demux_if.sv
// Lane-word bus between the serializing mux, the demux and its consumer.
// The master side feeds the serial stream; the slave side is the demux.
interface phy_rx_demux_if #(
  parameter int WIDTH = 9
);
  logic             align;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic             out_strobe;
  logic [7:0]       frame_count;

  modport master (
    output align, in_data,
    input  data0, data1, data2, data3, out_strobe, frame_count
  );

  modport slave (
    input  align, in_data,
    output data0, data1, data2, data3, out_strobe, frame_count
  );
endinterface

// File: rtl/phy_rx_demux.sv
// De-serializes a 4-lane word stream back into parallel lanes; align restarts
// framing at lane 0 and always wins over frame completion.
//
// state | meaning
// LANE0 | next word lands in stage0 (start of frame)
// LANE1 | next word lands in stage1
// LANE2 | next word lands in stage2
// LANE3 | next word completes the frame and updates data0..data3
module phy_rx_demux #(
  parameter int WIDTH = 9
) (
  input  logic            clk_4f,
  input  logic            reset,
  phy_rx_demux_if.slave   bus
);

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_e;

  lane_e            lane_sel;
  lane_e            lane_nxt;
  logic [1:0]       stage_idx;
  logic             stage_we;
  logic             complete;
  logic [WIDTH-1:0] stage0;
  logic [WIDTH-1:0] stage1;
  logic [WIDTH-1:0] stage2;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      lane_sel <= LANE0;
    end else begin
      lane_sel <= lane_nxt;
    end
  end

  // align overrides the lane position, so a collision at LANE3 never completes
  always_comb begin
    lane_nxt  = lane_sel;
    stage_idx = 2'd0;
    stage_we  = 1'b0;
    complete  = 1'b0;
    if (bus.align) begin
      lane_nxt  = LANE1;
      stage_idx = 2'd0;
      stage_we  = 1'b1;
    end else begin
      case (lane_sel)
        LANE0: begin
          lane_nxt  = LANE1;
          stage_idx = 2'd0;
          stage_we  = 1'b1;
        end
        LANE1: begin
          lane_nxt  = LANE2;
          stage_idx = 2'd1;
          stage_we  = 1'b1;
        end
        LANE2: begin
          lane_nxt  = LANE3;
          stage_idx = 2'd2;
          stage_we  = 1'b1;
        end
        LANE3: begin
          lane_nxt = LANE0;
          complete = 1'b1;
        end
        default: lane_nxt = LANE0;
      endcase
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      stage0          <= '0;
      stage1          <= '0;
      stage2          <= '0;
      bus.data0       <= '0;
      bus.data1       <= '0;
      bus.data2       <= '0;
      bus.data3       <= '0;
      bus.out_strobe  <= 1'b0;
      bus.frame_count <= 8'd0;
    end else begin
      bus.out_strobe <= complete;
      if (stage_we) begin
        case (stage_idx)
          2'd0:    stage0 <= bus.in_data;
          2'd1:    stage1 <= bus.in_data;
          default: stage2 <= bus.in_data;
        endcase
      end
      // lane 3 bypasses staging so the frame is out one edge after its last word
      if (complete) begin
        bus.data0       <= stage0;
        bus.data1       <= stage1;
        bus.data2       <= stage2;
        bus.data3       <= bus.in_data;
        bus.frame_count <= bus.frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_demux.sv
// Randomized and directed bench for phy_rx_demux against a queue-based frame
// model, plus literal expectations for the hand-worked scenarios.
module tb_phy_rx_demux;

  localparam int WIDTH = 9;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;

  phy_rx_demux_if #(.WIDTH(WIDTH)) bus ();

  phy_rx_demux #(.WIDTH(WIDTH)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_4f = ~clk_4f;

  int checks = 0;
  int errors = 0;

  // model: words collected since the last frame boundary
  logic [WIDTH-1:0] part[$];
  logic [WIDTH-1:0] exp_d[4];
  logic             exp_strobe = 1'b0;
  int               exp_cnt    = 0;
  bit               model_on   = 1'b0;
  logic             prev_strobe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_4f) begin
    if (reset) begin
      part.delete();
      for (int i = 0; i < 4; i++) exp_d[i] = '0;
      exp_strobe = 1'b0;
      exp_cnt    = 0;
      model_on   = 1'b1;
    end else if (bus.align) begin
      part.delete();
      part.push_back(bus.in_data);
      exp_strobe = 1'b0;
    end else begin
      part.push_back(bus.in_data);
      exp_strobe = 1'b0;
      if (part.size() == 4) begin
        for (int i = 0; i < 4; i++) exp_d[i] = part[i];
        exp_strobe = 1'b1;
        exp_cnt    = (exp_cnt + 1) % 256;
        part.delete();
      end
    end
  end

  always @(negedge clk_4f) begin
    if (model_on) begin
      chk("data0", 32'(bus.data0), 32'(exp_d[0]));
      chk("data1", 32'(bus.data1), 32'(exp_d[1]));
      chk("data2", 32'(bus.data2), 32'(exp_d[2]));
      chk("data3", 32'(bus.data3), 32'(exp_d[3]));
      chk("out_strobe", 32'(bus.out_strobe), 32'(exp_strobe));
      chk("frame_count", 32'(bus.frame_count), 32'(exp_cnt));
      if (prev_strobe) chk("strobe_gap", 32'(bus.out_strobe), 32'd0);
      prev_strobe = bus.out_strobe;
    end
  end

  // one word per cycle; returns after the consuming edge, outputs settled
  task automatic send(input logic rst, input logic al, input logic [WIDTH-1:0] d);
    reset       = rst;
    bus.align   = al;
    bus.in_data = d;
    @(negedge clk_4f);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                            input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3);
    send(1'b0, 1'b0, w0);
    send(1'b0, 1'b0, w1);
    send(1'b0, 1'b0, w2);
    send(1'b0, 1'b0, w3);
  endtask

  task automatic chk_frame(input string name, input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                           input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3);
    chk({name, "_d0"}, 32'(bus.data0), 32'(w0));
    chk({name, "_d1"}, 32'(bus.data1), 32'(w1));
    chk({name, "_d2"}, 32'(bus.data2), 32'(w2));
    chk({name, "_d3"}, 32'(bus.data3), 32'(w3));
  endtask

  initial begin
    int strobe_at[$];
    int cyc;
    bus.align   = 1'b0;
    bus.in_data = '0;
    @(negedge clk_4f);
    send(1'b1, 1'b0, 9'h000);
    chk("reset_count", 32'(bus.frame_count), 32'd0);
    chk("reset_strobe", 32'(bus.out_strobe), 32'd0);
    chk_frame("reset", 9'h000, 9'h000, 9'h000, 9'h000);

    // basic frame
    send_frame(9'h101, 9'h102, 9'h103, 9'h104);
    chk_frame("basic", 9'h101, 9'h102, 9'h103, 9'h104);
    chk("basic_strobe", 32'(bus.out_strobe), 32'd1);
    chk("basic_count", 32'(bus.frame_count), 32'd1);
    send(1'b0, 1'b0, 9'h055);
    chk("basic_strobe_drop", 32'(bus.out_strobe), 32'd0);

    // back-to-back frames with strobe spacing, restarted from reset
    send(1'b1, 1'b0, 9'h000);
    cyc = 0;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 4; l++) begin
        send(1'b0, 1'b0, 9'(16 * f + l + 9'h020));
        cyc++;
        if (bus.out_strobe) strobe_at.push_back(cyc);
      end
      chk_frame("b2b", 9'(16 * f + 9'h020), 9'(16 * f + 9'h021),
                9'(16 * f + 9'h022), 9'(16 * f + 9'h023));
    end
    chk("b2b_count", 32'(bus.frame_count), 32'd3);
    chk("b2b_nstrobe", 32'(strobe_at.size()), 32'd3);
    if (strobe_at.size() == 3) begin
      chk("b2b_gap1", 32'(strobe_at[1] - strobe_at[0]), 32'd4);
      chk("b2b_gap2", 32'(strobe_at[2] - strobe_at[1]), 32'd4);
    end

    // realignment drops the partial frame
    send(1'b0, 1'b0, 9'h1AA);
    send(1'b0, 1'b0, 9'h1BB);
    send(1'b0, 1'b1, 9'h111);
    chk("realign_nostrobe", 32'(bus.out_strobe), 32'd0);
    send(1'b0, 1'b0, 9'h122);
    send(1'b0, 1'b0, 9'h133);
    chk("realign_nostrobe2", 32'(bus.out_strobe), 32'd0);
    send(1'b0, 1'b0, 9'h144);
    chk_frame("realign", 9'h111, 9'h122, 9'h133, 9'h144);
    chk("realign_count", 32'(bus.frame_count), 32'd4);

    // align colliding with lane 3
    send(1'b0, 1'b0, 9'h021);
    send(1'b0, 1'b0, 9'h022);
    send(1'b0, 1'b0, 9'h023);
    send(1'b0, 1'b1, 9'h031);
    chk("collide_strobe", 32'(bus.out_strobe), 32'd0);
    chk_frame("collide_hold", 9'h111, 9'h122, 9'h133, 9'h144);
    send(1'b0, 1'b0, 9'h032);
    send(1'b0, 1'b0, 9'h033);
    send(1'b0, 1'b0, 9'h034);
    chk_frame("collide_next", 9'h031, 9'h032, 9'h033, 9'h034);
    chk("collide_count", 32'(bus.frame_count), 32'd5);

    // reset mid-frame
    send(1'b0, 1'b0, 9'h0E1);
    send(1'b0, 1'b0, 9'h0E2);
    send(1'b1, 1'b1, 9'h0E3);
    chk_frame("midrst", 9'h000, 9'h000, 9'h000, 9'h000);
    chk("midrst_count", 32'(bus.frame_count), 32'd0);
    send_frame(9'h1C1, 9'h0C2, 9'h1C3, 9'h0C4);
    chk_frame("midrst_new", 9'h1C1, 9'h0C2, 9'h1C3, 9'h0C4);
    chk("midrst_newcount", 32'(bus.frame_count), 32'd1);

    // 256 frames with invalid words, counter wraps
    send(1'b1, 1'b0, 9'h000);
    for (int f = 0; f < 256; f++) begin
      send_frame(9'h0FF, 9'h000, 9'h1FF, 9'h000);
      if (f == 254) chk("wrap_255", 32'(bus.frame_count), 32'd255);
    end
    chk("wrap_count", 32'(bus.frame_count), 32'd0);
    chk_frame("wrap", 9'h0FF, 9'h000, 9'h1FF, 9'h000);

    // random traffic with sporadic align and reset
    for (int n = 0; n < 3000; n++) begin
      send(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
           9'($urandom_range(0, 511)));
    end

    send(1'b0, 1'b0, 9'h000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
